// File: rtl/hi_lo_acc.sv
// hi_lo_acc: parametrised HI/LO register pair with forwarding, paired write and two-cycle MADD/MSUB accumulate
module hi_lo_acc #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op,
    output logic            op_ready,
    input  logic [DW-1:0]   hi_i,
    input  logic [DW-1:0]   lo_i,
    input  logic [2*DW-1:0] prod_i,
    input  logic            flush,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            busy
);
    typedef enum logic {IDLE, ACC} state_t;
    localparam logic [2:0] WHI = 3'd1, WLO = 3'd2, WPAIR = 3'd3, MADD = 3'd4, MSUB = 3'd5;
    state_t state, state_nx;
    logic [DW-1:0] hi_q, lo_q, hi_new, lo_new;
    logic [2*DW-1:0] prod_q, acc_sum;
    logic sub_q, accept, wr_hi, wr_lo, start;
    always_comb begin
        op_ready = rst_n && state == IDLE && !flush;
        accept   = op_valid && op_ready;
        wr_hi    = accept && (op == WHI || op == WPAIR);
        wr_lo    = accept && (op == WLO || op == WPAIR);
        start    = accept && (op == MADD || op == MSUB);
        hi_new   = op == WPAIR ? prod_i[2*DW-1:DW] : hi_i;
        lo_new   = op == WPAIR ? prod_i[DW-1:0] : lo_i;
        acc_sum  = sub_q ? {hi_q, lo_q} - prod_q : {hi_q, lo_q} + prod_q;
        state_nx = state == IDLE && start ? ACC : IDLE;
        busy     = state == ACC;
        hi_o     = !rst_n ? '0 : wr_hi ? hi_new : hi_q;
        lo_o     = !rst_n ? '0 : wr_lo ? lo_new : lo_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            prod_q <= '0;
            sub_q  <= 1'b0;
        end else if (state == ACC) begin
            // a flush during ACC drops the accumulate entirely
            if (!flush) {hi_q, lo_q} <= acc_sum;
        end else begin
            if (wr_hi) hi_q <= hi_new;
            if (wr_lo) lo_q <= lo_new;
            if (start) begin
                prod_q <= prod_i;
                sub_q  <= op == MSUB;
            end
        end
    end
endmodule

// File: tb/tb_hi_lo_acc.sv
// tb_hi_lo_acc: table vectors, hand-written corner sequences and a randomized run against a pair-level model
module tb_hi_lo_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, op_valid, flush, op_ready, busy;
    logic [2:0]  op;
    logic [31:0] hi_i, lo_i, hi_o, lo_o;
    logic [63:0] prod_i;
    logic        v16, f16, r16, b16;
    logic [2:0]  op16;
    logic [15:0] hi16_i, lo16_i, hi16_o, lo16_o;
    logic [31:0] prod16;
    int vectors = 0, miscompares = 0;

    hi_lo_acc #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .hi_i(hi_i), .lo_i(lo_i), .prod_i(prod_i), .flush(flush),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
    );
    hi_lo_acc #(.DW(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .op_valid(v16), .op(op16), .op_ready(r16),
        .hi_i(hi16_i), .lo_i(lo16_i), .prod_i(prod16), .flush(f16),
        .hi_o(hi16_o), .lo_o(lo16_o), .busy(b16)
    );

    typedef struct {
        logic v; logic [2:0] o; logic [31:0] h, l; logic [63:0] p; logic f;
        logic [31:0] eh, el; logic eb, er;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect4(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic eb, input logic er);
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
        chk({tag, "_busy"}, busy, eb);
        chk({tag, "_ready"}, op_ready, er);
    endtask

    task automatic cyc(input logic v, input logic [2:0] o, input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] p, input logic f);
        @(posedge clk); #1;
        op_valid = v; op = o; hi_i = h; lo_i = l; prod_i = p; flush = f;
        @(negedge clk);
    endtask

    task automatic cyc16(input logic v, input logic [2:0] o, input logic [31:0] p);
        @(posedge clk); #1;
        v16 = v; op16 = o; prod16 = p;
        @(negedge clk);
    endtask

    task automatic expect16(input string tag, input logic [15:0] eh, input logic [15:0] el,
                            input logic eb, input logic er);
        chk({tag, "_hi"}, hi16_o, eh);
        chk({tag, "_lo"}, lo16_o, el);
        chk({tag, "_busy"}, b16, eb);
        chk({tag, "_ready"}, r16, er);
    endtask

    logic [63:0] m_acc, m_prod;
    logic        m_pend, m_sub;

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 32'h0, 32'h0, 64'h0000_0001_FFFF_FFFF, 1'b0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 3'd1, 32'h0, 32'h0, 64'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 3'd4, 32'h0, 32'h0, 64'h1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'h1, 32'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'd3, 32'h0, 32'h0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 3'd5, 32'h0, 32'h0, 64'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'd2, 32'h0, 32'h7, 64'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 3'd2, 32'h0, 32'h7, 64'h0, 1'b0, 32'hFFFF_FFFF, 32'h7, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'hFFFF_FFFF, 32'h7, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 3'd4, 32'h0, 32'h0, 64'h5, 1'b0, 32'hFFFF_FFFF, 32'h7, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b1, 32'hFFFF_FFFF, 32'h7, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'hFFFF_FFFF, 32'h7, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 3'd1, 32'h1234, 32'h0, 64'h0, 1'b1, 32'hFFFF_FFFF, 32'h7, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 3'd2, 32'h0, 32'h5, 64'h0, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 3'd6, 32'h99, 32'h99, 64'hAB, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 3'd4, 32'h0, 32'h0, 64'h10, 1'b1, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b1};

        rst_n = 1'b0; op_valid = 1'b1; op = 3'd3; hi_i = 32'h11; lo_i = 32'h22;
        prod_i = 64'hDEAD_BEEF_CAFE_F00D; flush = 1'b0;
        v16 = 1'b0; op16 = 3'd0; hi16_i = 16'h0; lo16_i = 16'h0; prod16 = 32'h0; f16 = 1'b0;
        #12;
        expect4("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; op_valid = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].v, tbl[i].o, tbl[i].h, tbl[i].l, tbl[i].p, tbl[i].f);
            expect4($sformatf("row%0d", i), tbl[i].eh, tbl[i].el, tbl[i].eb, tbl[i].er);
        end

        // reset landing in the middle of an accumulate
        cyc(1'b1, 3'd4, 32'h0, 32'h0, 64'h3, 1'b0);
        expect4("madd_pre_rst", 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        #1;
        chk("acc_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        expect4("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 64'h0, 1'b0);
        expect4("post_rst", 32'h0, 32'h0, 1'b0, 1'b1);

        cyc16(1'b1, 3'd3, 32'h0000_FFFF);
        expect16("w16_pair", 16'h0, 16'hFFFF, 1'b0, 1'b1);
        cyc16(1'b1, 3'd4, 32'h1);
        expect16("w16_madd", 16'h0, 16'hFFFF, 1'b0, 1'b1);
        cyc16(1'b0, 3'd0, 32'h0);
        expect16("w16_acc", 16'h0, 16'hFFFF, 1'b1, 1'b0);
        cyc16(1'b0, 3'd0, 32'h0);
        expect16("w16_sum", 16'h1, 16'h0, 1'b0, 1'b1);

        m_acc = 64'h0; m_prod = 64'h0; m_pend = 1'b0; m_sub = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic        v, f, ok, er;
            logic [2:0]  o;
            logic [31:0] h, l, eh, el;
            logic [63:0] p;
            v = $urandom_range(0, 3) != 0;
            o = 3'($urandom_range(0, 7));
            f = $urandom_range(0, 7) == 0;
            h = $urandom; l = $urandom;
            case ($urandom_range(0, 3))
                0:       p = 64'h1;
                1:       p = {32'h0, 32'hFFFF_FFFF};
                default: p = {$urandom, $urandom};
            endcase
            cyc(v, o, h, l, p, f);
            er = !m_pend && !f;
            ok = v && er;
            eh = ok && o == 3'd3 ? p[63:32] : ok && o == 3'd1 ? h : m_acc[63:32];
            el = ok && o == 3'd3 ? p[31:0]  : ok && o == 3'd2 ? l : m_acc[31:0];
            expect4($sformatf("rnd%0d", n), eh, el, m_pend, er);
            if (m_pend) begin
                if (!f) m_acc = m_sub ? m_acc - m_prod : m_acc + m_prod;
                m_pend = 1'b0;
            end else if (ok) begin
                if (o == 3'd1) m_acc[63:32] = h;
                if (o == 3'd2) m_acc[31:0] = l;
                if (o == 3'd3) m_acc = p;
                if (o == 3'd4 || o == 3'd5) begin
                    m_pend = 1'b1;
                    m_prod = p;
                    m_sub  = o == 3'd5;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
